// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS pipeline: instruction width, opcodes,
// the NOP encoding and the fetch FSM state type.
package mips_pkg;

    localparam int INS_W = 20;

    localparam logic [4:0] OP_HLT     = 5'b10001;
    localparam logic [4:0] OP_LD      = 5'b10100;
    localparam logic [2:0] OP_JMP_PFX = 3'b111;

    localparam logic [INS_W-1:0] NOP = 20'h00000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_hlt(input logic [INS_W-1:0] ins);
        return ins[INS_W-1:INS_W-5] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: stall-control and execute inputs, program-memory address
// and the fetch/decode register outputs.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    import mips_pkg::*;

    logic              stall;
    logic              stall_pm;
    logic [INS_W-1:0]  ins_pm;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;
    logic [ADDR_W-1:0] pm_addr;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic              replay;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        input  stall, stall_pm, ins_pm, jmp_en, jmp_addr,
        output pm_addr, ins_out, ins_valid, replay, halted, stall_cnt
    );

    modport slave (
        output stall, stall_pm, ins_pm, jmp_en, jmp_addr,
        input  pm_addr, ins_out, ins_valid, replay, halted, stall_cnt
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: load has priority over increment; otherwise holds.
// Wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers the fetched instruction,
// inserts bubbles on stall, freezes on HLT and redirects on a taken jump.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
);

    fetch_state_e      state_d, state_q;
    logic [INS_W-1:0]  ins_out_d, ins_out_q;
    logic              ins_valid_d, ins_valid_q;
    logic              replay_d, replay_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (bus.jmp_addr),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Every branch that does not fetch leaves a bubble, so the defaults are NOP.
    always_comb begin
        state_d     = state_q;
        ins_out_d   = NOP;
        ins_valid_d = 1'b0;
        replay_d    = 1'b0;
        stall_cnt_d = stall_cnt_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;

        if (bus.jmp_en) begin
            pc_load = 1'b1;
            state_d = ST_RUN;
        end else if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (is_hlt(bus.ins_pm)) begin
            state_d     = ST_HALT;
            ins_out_d   = bus.ins_pm;
            ins_valid_d = 1'b1;
        end else if (bus.stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            pc_inc      = 1'b1;
            ins_out_d   = bus.ins_pm;
            ins_valid_d = 1'b1;
            replay_d    = bus.stall_pm;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            ins_out_q   <= NOP;
            ins_valid_q <= 1'b0;
            replay_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ins_out_q   <= ins_out_d;
            ins_valid_q <= ins_valid_d;
            replay_q    <= replay_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pm_addr   = pc;
    assign bus.ins_out   = ins_out_q;
    assign bus.ins_valid = ins_valid_q;
    assign bus.replay    = replay_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.stall_cnt = stall_cnt_q;

endmodule
